// File: rtl/arb_types_pkg.sv
// arb_types_pkg: arbiter state encoding and counter limits.
package arb_types_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, LOCK, ERRW} arb_state_t;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word and RAM handshake types.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick of the first pending requester at or after rr_ptr.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] pend,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [IDW-1:0]  winner,
    output logic            any
);
    logic [IDW:0] s;
    always_comb begin
        winner = '0;
        any    = 1'b0;
        s      = '0;
        // scan downward so the closest requester to rr_ptr is assigned last and wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            s = {1'b0, rr_ptr} + (IDW+1)'(k);
            s = (s >= (IDW+1)'(NREQ)) ? s - (IDW+1)'(NREQ) : s;
            if (pend[s[IDW-1:0]]) begin
                winner = s[IDW-1:0];
                any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_request_arbiter.sv
// ram_request_arbiter: round-robin owner of the single RAM port with locked multi-word sequences.
// Optional RAM_ARB_STATS_EN adds saturating per-requester completed-access counters on grant_cnt.
module ram_request_arbiter
    import cpu_types_pkg::*;
    import arb_types_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req_ren,
    input  logic [NREQ-1:0]        req_wen,
    input  logic [NREQ-1:0]        req_lock,
    input  word_t [NREQ-1:0]       req_addr,
    input  word_t [NREQ-1:0]       req_store,
    output logic [NREQ-1:0]        req_wait,
    output word_t [NREQ-1:0]       req_load,
    output logic                   ramREN,
    output logic                   ramWEN,
    output word_t                  ramaddr,
    output word_t                  ramstore,
    input  word_t                  ramload,
    input  ramstate_t              ramstate,
    output logic [IDW-1:0]         grant_id,
    output logic                   arb_err
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [NREQ-1:0][15:0]  grant_cnt
`endif
);
    arb_state_t state, state_n;
    logic [IDW-1:0] owner, owner_n, rr_ptr, rr_ptr_n, winner, own_next;
    logic any, own_ren, own_wen, own_lock, own_act, serve, acc, err;

    assign own_ren  = req_ren[owner];
    assign own_wen  = req_wen[owner];
    assign own_lock = req_lock[owner];
    assign own_act  = own_ren | own_wen;
    assign own_next = (owner == IDW'(NREQ - 1)) ? '0 : owner + IDW'(1);
    assign serve    = (state == GRANT) || (state == LOCK);
    assign acc      = ramstate == ACCESS;
    assign err      = ramstate == ERROR;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .pend   (req_ren | req_wen),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            owner  <= owner_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        case (state)
            IDLE:  begin
                state_n = any ? GRANT : IDLE;
                owner_n = any ? winner : owner;
            end
            GRANT: state_n = err ? ERRW : (!own_act || (acc && !own_lock)) ? IDLE : acc ? LOCK : GRANT;
            LOCK:  state_n = err ? ERRW : (!own_lock && (!own_act || acc)) ? IDLE : LOCK;
            ERRW:  state_n = err ? ERRW : IDLE;
            default: state_n = IDLE;
        endcase
        // any way of leaving ownership hands priority to the next requester
        if (state != IDLE && state_n == IDLE)
            rr_ptr_n = own_next;
    end

    always_comb begin
        req_wait = '1;
        req_load = '0;
        if (serve) begin
            req_wait[owner] = !acc;
            req_load[owner] = ramload;
        end
        ramREN   = serve & own_ren & ~own_wen;
        ramWEN   = serve & own_wen;
        ramaddr  = serve ? req_addr[owner] : '0;
        ramstore = serve ? req_store[owner] : '0;
        arb_err  = serve & err;
        grant_id = (state == IDLE) ? '0 : owner;
    end

`ifdef RAM_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST)
            grant_cnt <= '0;
        else if (serve && acc && grant_cnt[owner] != CNT_MAX)
            grant_cnt[owner] <= grant_cnt[owner] + 16'd1;
    end
`endif
endmodule
